sfr_reg_block: RTL and testbench



---
 rtl/sfr_reg_block.sv | 144 ++++++++++++++
 tb/tb_sfr_reg_block.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfr_reg_block.sv
// SFR slave: scratch registers, control, W1C status, free-running counter
// and a two-key write lock, with a level interrupt on enabled status events.
module sfr_reg_block #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] LOCK_KEY    = 8'hA5,
    parameter logic [7:0] SCRATCH_RST = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] address,
    input  logic [7:0] write_data,
    output logic [7:0] read_data,
    input  logic       we,
    input  logic       re,
    output logic       irq,
    output logic       locked
);

    localparam logic [7:0] NREG      = NUM_REGS[7:0];
    localparam logic [7:0] ADDR_CTRL = 8'h10;
    localparam logic [7:0] ADDR_STAT = 8'h11;
    localparam logic [7:0] ADDR_CNT  = 8'h12;
    localparam logic [7:0] ADDR_LOCK = 8'h13;

    typedef enum logic [1:0] {UNLOCKED, LOCKED, ARMED} lock_e;

    lock_e       state_q, state_d;
    logic [7:0]  scr_q [NUM_REGS];
    logic [1:0]  ctrl_q, ctrl_d;
    logic [7:0]  count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        err_q, err_d;
    logic        irq_q, irq_d;

    logic hit_scr, hit_ctrl, hit_stat, hit_cnt, hit_lock, mapped;
    logic guarded, wr_ok, lock_viol, key2, arm_fail;
    logic cnt_wr, wrap, w1c, err_set;
    logic [7:0] scr_rd;

    assign hit_scr  = address < NREG;
    assign hit_ctrl = address == ADDR_CTRL;
    assign hit_stat = address == ADDR_STAT;
    assign hit_cnt  = address == ADDR_CNT;
    assign hit_lock = address == ADDR_LOCK;
    assign mapped   = hit_scr | hit_ctrl | hit_stat | hit_cnt | hit_lock;

    // Only scratch, CTRL and COUNT are protected by the lock
    assign guarded   = hit_scr | hit_ctrl | hit_cnt;
    assign wr_ok     = we & guarded & ~locked;
    assign lock_viol = we & guarded & locked;
    assign key2      = we & hit_lock & (write_data == ~LOCK_KEY);
    assign arm_fail  = we & (state_q == ARMED) & ~key2;

    assign err_set = (re & ~mapped) | (we & re) | (we & ~mapped)
                   | lock_viol | arm_fail;

    assign cnt_wr = wr_ok & hit_cnt;
    assign wrap   = ctrl_q[0] & ~cnt_wr & (count_q == 8'hFF);
    assign w1c    = we & hit_stat;

    always_comb begin
        count_d = count_q;
        if (cnt_wr)
            count_d = write_data;
        else if (ctrl_q[0])
            count_d = count_q + 8'd1;
    end

    // Hardware set beats a same-cycle W1C clear
    assign ovf_d  = (ovf_q & ~(w1c & write_data[0])) | wrap;
    assign err_d  = (err_q & ~(w1c & write_data[1])) | err_set;
    assign ctrl_d = (wr_ok & hit_ctrl) ? write_data[1:0] : ctrl_q;
    assign irq_d  = ctrl_d[1] & (ovf_d | err_d);

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            irq_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++)
                scr_q[i] <= SCRATCH_RST;
        end else begin
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            irq_q   <= irq_d;
            for (int i = 0; i < NUM_REGS; i++)
                if (wr_ok && hit_scr && address == 8'(i))
                    scr_q[i] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= UNLOCKED;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (we) begin
            unique case (state_q)
                UNLOCKED: if (hit_lock && write_data != LOCK_KEY)
                              state_d = LOCKED;
                LOCKED:   if (hit_lock && write_data == LOCK_KEY)
                              state_d = ARMED;
                ARMED:    state_d = key2 ? UNLOCKED : LOCKED;
                default:  state_d = UNLOCKED;
            endcase
        end
    end

    always_comb begin
        locked = state_q != UNLOCKED;
    end

    always_comb begin
        scr_rd = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (address == 8'(i))
                scr_rd = scr_q[i];
    end

    // Collision cycles return zero while still performing the write
    always_comb begin
        read_data = '0;
        if (re && !we) begin
            unique case (1'b1)
                hit_scr:  read_data = scr_rd;
                hit_ctrl: read_data = {6'b0, ctrl_q};
                hit_stat: read_data = {5'b0, locked, err_q, ovf_q};
                hit_cnt:  read_data = count_q;
                default:  read_data = '0;
            endcase
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_sfr_reg_block.sv
// Randomized bench for sfr_reg_block with an in-bench register model,
// per-cycle output comparison and directed literal checks.
module tb_sfr_reg_block;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] address;
    logic [7:0] write_data;
    logic [7:0] read_data;
    logic       we;
    logic       re;
    logic       irq;
    logic       locked;

    int checks = 0;
    int errors = 0;

    sfr_reg_block dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .we         (we),
        .re         (re),
        .irq        (irq),
        .locked     (locked)
    );

    always #5 clk = ~clk;

    // Register model: 0=unlocked, 1=locked, 2=armed
    logic [7:0] m_scr [16];
    logic [1:0] m_ctrl;
    logic [7:0] m_cnt;
    bit         m_ovf, m_err;
    int         m_st;
    bit         m_valid = 0;

    task automatic chk(input string n, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     n, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] m_rd(input logic [7:0] a);
        if (a < 8'd16) return m_scr[a[3:0]];
        case (a)
            8'h10:   return {6'b0, m_ctrl};
            8'h11:   return {5'b0, m_st != 0, m_err, m_ovf};
            8'h12:   return m_cnt;
            default: return 8'h00;
        endcase
    endfunction

    task automatic m_step();
        logic [7:0] a, d;
        bit e, lk, wrc, wrp, clr_o, clr_e, old_en;
        if (reset) begin
            for (int i = 0; i < 16; i++) m_scr[i] = 8'h00;
            m_ctrl = 0; m_cnt = 0; m_ovf = 0; m_err = 0; m_st = 0;
            m_valid = 1;
            return;
        end
        if (!m_valid) return;
        a = address; d = write_data;
        lk = (m_st != 0);
        e = 0; wrc = 0; wrp = 0; clr_o = 0; clr_e = 0;
        old_en = m_ctrl[0];
        if (re && a > 8'h13) e = 1;
        if (we && re) e = 1;
        if (we) begin
            if (a < 8'd16 || a == 8'h10 || a == 8'h12) begin
                if (lk) e = 1;
                else if (a < 8'd16) m_scr[a[3:0]] = d;
                else if (a == 8'h10) m_ctrl = d[1:0];
                else begin m_cnt = d; wrc = 1; end
            end else if (a == 8'h11) begin
                clr_o = d[0]; clr_e = d[1];
            end else if (a != 8'h13) begin
                e = 1;
            end
            case (m_st)
                0: if (a == 8'h13 && d != 8'hA5) m_st = 1;
                1: if (a == 8'h13 && d == 8'hA5) m_st = 2;
                default: begin
                    if (a == 8'h13 && d == 8'h5A) m_st = 0;
                    else begin m_st = 1; e = 1; end
                end
            endcase
        end
        if (!wrc && old_en) begin
            if (m_cnt == 8'hFF) wrp = 1;
            m_cnt = m_cnt + 8'd1;
        end
        m_ovf = (m_ovf && !clr_o) || wrp;
        m_err = (m_err && !clr_e) || e;
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("read_data", read_data,
                (re && !we) ? m_rd(address) : 8'h00);
            chk("irq", {7'b0, irq}, {7'b0, m_ctrl[1] & (m_ovf | m_err)});
            chk("locked", {7'b0, locked}, {7'b0, m_st != 0});
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [7:0] a,
                       input logic [7:0] d, input bit rst);
        we = w; re = r; address = a; write_data = d; reset = rst;
        @(posedge clk);
        m_step();
        #1;
        we = 0; re = 0; reset = 0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        cyc(1, 0, a, d, 0);
    endtask

    task automatic idle();
        cyc(0, 0, 8'h00, 8'h00, 0);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp,
                      input string n);
        we = 0; re = 1; address = a; write_data = 0; reset = 0;
        @(negedge clk);
        chk(n, read_data, exp);
        @(posedge clk);
        m_step();
        #1;
        re = 0;
    endtask

    task automatic rnd_cyc();
        logic [7:0] a, d;
        int k;
        k = $urandom_range(0, 9);
        if (k < 5)      a = 8'($urandom_range(0, 15));
        else if (k < 9) a = 8'h10 + 8'($urandom_range(0, 3));
        else            a = 8'($urandom);
        k = $urandom_range(0, 3);
        d = (k == 0) ? 8'hA5 : (k == 1) ? 8'h5A : 8'($urandom);
        cyc($urandom_range(0, 9) < 4, $urandom_range(0, 9) < 4, a, d,
            $urandom_range(0, 199) == 0);
    endtask

    initial begin
        reset = 1; we = 0; re = 0; address = 0; write_data = 0;
        cyc(0, 0, 0, 0, 1);
        repeat (60) rnd_cyc();
        cyc(0, 0, 0, 0, 1);
        chk("rst_locked", {7'b0, locked}, 8'h00);
        chk("rst_irq", {7'b0, irq}, 8'h00);
        for (int i = 0; i <= 8'h13; i++)
            rd(8'(i), 8'h00, "rst_read");

        wr(8'h05, 8'h3C);
        rd(8'h05, 8'h3C, "scr5");
        rd(8'h40, 8'h00, "unmapped_rd");
        rd(8'h11, 8'h02, "unmapped_err");
        wr(8'h11, 8'h02);
        rd(8'h11, 8'h00, "err_clr");

        wr(8'h13, 8'h00);
        chk("lock_on", {7'b0, locked}, 8'h01);
        wr(8'h05, 8'h77);
        rd(8'h05, 8'h3C, "locked_drop");
        rd(8'h11, 8'h06, "locked_err");
        wr(8'h13, 8'hA5);
        chk("armed_locked", {7'b0, locked}, 8'h01);
        wr(8'h13, 8'h5A);
        chk("unlock", {7'b0, locked}, 8'h00);
        wr(8'h11, 8'h02);
        wr(8'h13, 8'h00);
        wr(8'h13, 8'hA5);
        wr(8'h02, 8'h11);
        chk("arm_fail_lock", {7'b0, locked}, 8'h01);
        rd(8'h11, 8'h06, "arm_fail_err");
        rd(8'h02, 8'h00, "arm_fail_drop");
        wr(8'h13, 8'hA5);
        wr(8'h13, 8'h5A);
        wr(8'h11, 8'h02);

        wr(8'h12, 8'hFE);
        wr(8'h10, 8'h03);
        rd(8'h12, 8'hFE, "cnt_fe");
        rd(8'h12, 8'hFF, "cnt_ff");
        chk("ovf_irq", {7'b0, irq}, 8'h01);
        rd(8'h11, 8'h01, "ovf_set");
        wr(8'h11, 8'h01);
        chk("irq_clr", {7'b0, irq}, 8'h00);
        rd(8'h11, 8'h00, "ovf_clr");

        wr(8'h12, 8'hFF);
        wr(8'h11, 8'h01);
        rd(8'h11, 8'h01, "w1c_vs_wrap");
        wr(8'h11, 8'h01);
        wr(8'h12, 8'h10);
        idle();
        idle();
        rd(8'h12, 8'h12, "cnt_override");
        wr(8'h10, 8'h00);

        we = 1; re = 1; address = 8'h05; write_data = 8'h99;
        @(negedge clk);
        chk("collide_rd", read_data, 8'h00);
        @(posedge clk);
        m_step();
        #1;
        we = 0; re = 0;
        rd(8'h05, 8'h99, "collide_wr");
        rd(8'h11, 8'h02, "collide_err");
        wr(8'h11, 8'h02);

        wr(8'h13, 8'h00);
        wr(8'h13, 8'hA5);
        cyc(0, 0, 0, 0, 1);
        chk("armed_reset", {7'b0, locked}, 8'h00);
        rd(8'h11, 8'h00, "armed_reset_st");

        repeat (3000) rnd_cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
